// File: rtl/ahb_master_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one AHB-Lite master port, one single-beat NONSEQ transfer at a time.
// Define AHB_ARB_RR_EN for round-robin tie-breaking; otherwise data requests win every tie.
module ahb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // Latched copy of the granted request; also drives the address-phase outputs.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [2:0]            size;
    logic [DATA_WIDTH-1:0] wdata;
  } xfer_t;

  state_t                state_q, state_d;
  xfer_t                 xfer_q, xfer_d;
  logic                  owner_q, owner_d;   // 1 = data requester owns the transfer
  logic [1:0]            htrans_q, htrans_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_done_q, i_done_d;
  logic                  i_err_q, i_err_d;
  logic                  d_done_q, d_done_d;
  logic                  d_err_q, d_err_d;
  logic                  grant_data;
`ifdef AHB_ARB_RR_EN
  logic                  last_q, last_d;     // last owner served, 0 = instruction
`endif

  // Tie-break between the two requesters
  always_comb begin
`ifdef AHB_ARB_RR_EN
    grant_data = (i_req && d_req) ? ~last_q : d_req;
`else
    grant_data = d_req;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    xfer_d    = xfer_q;
    owner_d   = owner_q;
    htrans_d  = htrans_q;
    hwdata_d  = hwdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    i_err_d   = 1'b0;
    d_done_d  = 1'b0;
    d_err_d   = 1'b0;
`ifdef AHB_ARB_RR_EN
    last_d    = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        htrans_d = HTRANS_IDLE;
        if (i_req || d_req) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          owner_d  = grant_data;
`ifdef AHB_ARB_RR_EN
          last_d   = grant_data;
`endif
          if (grant_data) begin
            xfer_d.addr  = d_addr;
            xfer_d.we    = d_we;
            xfer_d.size  = d_size;
            xfer_d.wdata = d_wdata;
          end else begin
            xfer_d.addr  = i_addr;
            xfer_d.we    = 1'b0;
            xfer_d.size  = HSIZE_WORD;
            xfer_d.wdata = '0;
          end
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hwdata_d = xfer_q.we ? xfer_q.wdata : '0;
        end
      end

      // Wait states hold here whatever HRESP says; the error's second cycle carries HREADY=1.
      ST_DATA: begin
        if (HREADY) begin
          state_d  = ST_RESP;
          hwdata_d = '0;
          if (!xfer_q.we) begin
            if (owner_q) d_rdata_d = HRDATA;
            else         i_rdata_d = HRDATA;
          end
          i_done_d = !owner_q && !HRESP;
          i_err_d  = !owner_q &&  HRESP;
          d_done_d =  owner_q && !HRESP;
          d_err_d  =  owner_q &&  HRESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      xfer_q    <= '0;
      owner_q   <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      hwdata_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
`ifdef AHB_ARB_RR_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      xfer_q    <= xfer_d;
      owner_q   <= owner_d;
      htrans_q  <= htrans_d;
      hwdata_q  <= hwdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      i_err_q   <= i_err_d;
      d_done_q  <= d_done_d;
      d_err_q   <= d_err_d;
`ifdef AHB_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign HADDR   = xfer_q.addr;
  assign HWRITE  = xfer_q.we;
  assign HSIZE   = xfer_q.size;
  assign HTRANS  = htrans_q;
  assign HWDATA  = hwdata_q;
  assign HBURST  = HBURST_SINGLE;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = i_done_q;
  assign i_err   = i_err_q;
  assign d_done  = d_done_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: scripted AHB slave plus response scoreboard.
module tb_ahb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done, i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done, d_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          aw;
    int          dw;
    logic        err;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic        is_data;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int unsigned cyc;
  } rsp_t;

  bus_t bq[$];
  rsp_t rq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scripted slave: expected address-phase values and wait/err profile per transfer
  bus_t cur;
  int   acnt = 0;
  int   dcnt = 0;
  bit   dph = 1'b0;

  always @(negedge clk) begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = $urandom;
    if (!reset) begin
      acnt = 0;
      dcnt = 0;
      dph  = 1'b0;
    end else if (dph) begin
      chk("htrans_data", 32'(HTRANS), 32'(2'b00));
      chk("hwdata", HWDATA, cur.hwrite ? cur.hwdata : 32'h0);
      if (dcnt < cur.dw) begin
        HREADY = 1'b0;
        HRESP  = cur.err && (dcnt == cur.dw - 1);
        dcnt++;
      end else begin
        HRESP  = cur.err;
        HRDATA = cur.rdata;
        dph    = 1'b0;
        dcnt   = 0;
      end
    end else if (HTRANS == 2'b10) begin
      if (bq.size() == 0) begin
        chk("unexpected_nonseq", 32'(1), 32'(0));
      end else begin
        cur = bq[0];
        chk("haddr", HADDR, cur.haddr);
        chk("hwrite", 32'(HWRITE), 32'(cur.hwrite));
        chk("hsize", 32'(HSIZE), 32'(cur.hsize));
        if (acnt < cur.aw) begin
          HREADY = 1'b0;
          acnt++;
        end else begin
          acnt = 0;
          dph  = 1'b1;
          void'(bq.pop_front());
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) begin : mon
    rsp_t e;
    if (reset && (i_done || i_err || d_done || d_err)) begin
      if (rq.size() == 0) begin
        chk("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        e = rq.pop_front();
        chk("i_done", 32'(i_done), 32'(!e.is_data && !e.err));
        chk("i_err",  32'(i_err),  32'(!e.is_data &&  e.err));
        chk("d_done", 32'(d_done), 32'(e.is_data && !e.err));
        chk("d_err",  32'(d_err),  32'(e.is_data &&  e.err));
        chk("done_cyc", cyc, e.cyc);
        if (e.chk_rd) chk(e.is_data ? "d_rdata" : "i_rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  task automatic push_xfer(input logic is_data, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int aw, input int dw,
                           input logic err, input int unsigned ecyc);
    bus_t b;
    rsp_t r;
    b.haddr = addr; b.hwrite = we; b.hsize = size; b.hwdata = wdata;
    b.aw = aw; b.dw = dw; b.err = err; b.rdata = rdata;
    bq.push_back(b);
    r.is_data = is_data; r.err = err; r.chk_rd = !we && !err; r.rdata = rdata; r.cyc = ecyc;
    rq.push_back(r);
  endtask

  // Requester side: drop req in the cycle its done/err is seen
  task automatic wait_pulse(input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (i_done || i_err) begin i_req = 1'b0; seen = 1'b1; end
      if (d_done || d_err) begin d_req = 1'b0; seen = 1'b1; end
    end
    if (!seen) chk("timeout", 32'(0), 32'(1));
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                          input int aw, input int dw, input logic err);
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = addr;
    push_xfer(1'b0, 1'b0, 3'b010, addr, 32'h0, rdata, aw, dw, err, cyc + 3 + 32'(aw + dw));
    wait_pulse(40);
  endtask

  task automatic do_data(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int aw, input int dw, input logic err);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    push_xfer(1'b1, we, size, addr, wdata, rdata, aw, dw, err, cyc + 3 + 32'(aw + dw));
    wait_pulse(40);
  endtask

  int unsigned t0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_htrans", 32'(HTRANS), 32'(0));
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'(0));
    chk("rst_hwrite", 32'(HWRITE), 32'(0));
    chk("rst_pulses", 32'({i_done, i_err, d_done, d_err}), 32'(0));
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    #1 reset = 1'b1;
    chk("hburst", 32'(HBURST), 32'(0));

    do_fetch(32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_data(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 2, 1'b0);
    do_data(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 3, 0, 1'b0);
    do_data(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0);
    do_data(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h0BAD_0BAD, 0, 1, 1'b1);
    do_fetch(32'h0000_0044, 32'h1234_5678, 0, 0, 1'b0);

    // Two ties in a row; last served before this point is the instruction side
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h0000_0200;
    t0 = cyc;
    push_xfer(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1111_2222, 0, 0, 1'b0, t0 + 3);
`ifdef AHB_ARB_RR_EN
    push_xfer(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h3333_4444, 0, 0, 1'b0, t0 + 7);
    push_xfer(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h5555_6666, 32'h0, 0, 0, 1'b0, t0 + 11);
`else
    push_xfer(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h5555_6666, 32'h0, 0, 0, 1'b0, t0 + 7);
    push_xfer(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h3333_4444, 0, 0, 1'b0, t0 + 11);
`endif
    wait_pulse(20);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h5555_6666;
    wait_pulse(20);
    wait_pulse(20);

    // Reset while a store sits in its data phase, then reissue
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 32'h0000_0400; d_wdata = 32'h1357_9BDF;
    push_xfer(1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h1357_9BDF, 32'h0, 0, 4, 1'b0, cyc + 7);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    d_req = 1'b0;
    #1;
    chk("abort_htrans", 32'(HTRANS), 32'(0));
    chk("abort_pulses", 32'({i_done, i_err, d_done, d_err}), 32'(0));
    chk("abort_hwdata", HWDATA, 32'h0);
    chk("abort_haddr", HADDR, 32'h0);
    bq.delete();
    rq.delete();
    @(negedge clk);
    #1 reset = 1'b1;
    do_data(1'b1, 3'b010, 32'h0000_0400, 32'h1357_9BDF, 32'h0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", 32'(bq.size()), 32'(0));
    chk("rsp_queue_drained", 32'(rq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
